// File: rtl/integer_issue_queue.sv
// Integer reservation station: age-ordered compacting queue (index 0 is oldest).
// Captures missing source operands from the CDB and presents the oldest entry
// whose operands are both valid to the integer execute block.
module integer_issue_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned OPC_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  // Dispatch
  input  logic                       dispatch_enable,
  input  logic [DATA_W-1:0]          dispatch_rs1_data,
  input  logic [DATA_W-1:0]          dispatch_rs2_data,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag,
  input  logic                       dispatch_rs1_data_val,
  input  logic                       dispatch_rs2_data_val,
  input  logic [OPC_W-1:0]           dispatch_opcode,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  output logic                       issueque_full,
  output logic [$clog2(DEPTH+1)-1:0] issueque_count,
  // Common data bus
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       cdb_valid,
  // Recovery
  input  logic                       issueque_flush,
  // Issue
  output logic                       issueque_ready,
  output logic [DATA_W-1:0]          issueque_rs_data,
  output logic [DATA_W-1:0]          issueque_rt_data,
  output logic [TAG_W-1:0]           issueque_rd_tag,
  output logic [OPC_W-1:0]           issueque_opcode,
  input  logic                       issueblk_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_val;
    logic [DATA_W-1:0] s2_data;
    logic [TAG_W-1:0]  s2_tag;
    logic              s2_val;
  } entry_t;

  entry_t            r_entries [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // Entry DEPTH is a permanently empty slot so the top entry shifts in "nothing".
  entry_t            w_woken   [DEPTH+1];
  entry_t            w_next    [DEPTH];
  entry_t            w_new;
  logic              w_full;
  logic              w_ready;
  logic [IDX_W-1:0]  w_sel;
  logic              w_issue;
  logic              w_dispatch;
  logic [CNT_W-1:0]  w_widx;
  logic [CNT_W-1:0]  w_count_next;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_dispatch = dispatch_enable & ~w_full;
  assign w_issue    = w_ready & issueblk_done;
  // When an issue removes one entry this cycle, the tail slides down by one.
  assign w_widx     = w_issue ? (r_count - CNT_W'(1)) : r_count;

  // CDB wakeup applied to every held entry before any shift.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = r_entries[i];
      if (cdb_valid && r_entries[i].valid) begin
        if (!r_entries[i].s1_val && (r_entries[i].s1_tag == cdb_tag)) begin
          w_woken[i].s1_data = cdb_data;
          w_woken[i].s1_val  = 1'b1;
        end
        if (!r_entries[i].s2_val && (r_entries[i].s2_tag == cdb_tag)) begin
          w_woken[i].s2_data = cdb_data;
          w_woken[i].s2_val  = 1'b1;
        end
      end
    end
    w_woken[DEPTH] = '0;
  end

  // Incoming entry, with same-cycle CDB bypass for unresolved sources.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.opcode  = dispatch_opcode;
    w_new.rd_tag  = dispatch_rd_tag;
    w_new.s1_data = dispatch_rs1_data;
    w_new.s1_tag  = dispatch_rs1_tag;
    w_new.s1_val  = dispatch_rs1_data_val;
    w_new.s2_data = dispatch_rs2_data;
    w_new.s2_tag  = dispatch_rs2_tag;
    w_new.s2_val  = dispatch_rs2_data_val;
    if (cdb_valid && !dispatch_rs1_data_val && (dispatch_rs1_tag == cdb_tag)) begin
      w_new.s1_data = cdb_data;
      w_new.s1_val  = 1'b1;
    end
    if (cdb_valid && !dispatch_rs2_data_val && (dispatch_rs2_tag == cdb_tag)) begin
      w_new.s2_data = cdb_data;
      w_new.s2_val  = 1'b1;
    end
  end

  // Oldest-ready select from registered state only (no CDB-to-issue forwarding).
  always_comb begin
    w_ready = 1'b0;
    w_sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_entries[i].valid && r_entries[i].s1_val && r_entries[i].s2_val) begin
        w_ready = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end

  // Compact over the issued slot, then place the dispatched entry at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (i >= int'(w_sel))) begin
        w_next[i] = w_woken[i+1];
      end else begin
        w_next[i] = w_woken[i];
      end
      if (w_dispatch && (int'(w_widx) == i)) begin
        w_next[i] = w_new;
      end
    end
  end

  // Occupancy: dispatch and issue in the same cycle cancel out.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_dispatch, w_issue})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // State update; reset and flush empty the queue and override everything else.
  always_ff @(posedge clk) begin
    if (reset || issueque_flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= w_next[i];
      end
    end
  end

  assign issueque_full    = w_full;
  assign issueque_count   = r_count;
  assign issueque_ready   = w_ready;
  assign issueque_rs_data = w_ready ? r_entries[w_sel].s1_data : '0;
  assign issueque_rt_data = w_ready ? r_entries[w_sel].s2_data : '0;
  assign issueque_rd_tag  = w_ready ? r_entries[w_sel].rd_tag  : '0;
  assign issueque_opcode  = w_ready ? r_entries[w_sel].opcode  : '0;

endmodule

// File: tb/tb_integer_issue_queue.sv
// Directed self-checking bench for integer_issue_queue (DEPTH=8, DATA_W=32, TAG_W=6).
module tb_integer_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_enable;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
  logic        dispatch_rs1_data_val, dispatch_rs2_data_val;
  logic [3:0]  dispatch_opcode;
  logic [5:0]  dispatch_rd_tag;
  logic        issueque_full;
  logic [3:0]  issueque_count;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_valid;
  logic        issueque_flush;
  logic        issueque_ready;
  logic [31:0] issueque_rs_data, issueque_rt_data;
  logic [5:0]  issueque_rd_tag;
  logic [3:0]  issueque_opcode;
  logic        issueblk_done;

  int checks = 0;
  int errors = 0;

  integer_issue_queue #(
    .DEPTH (8),
    .DATA_W(32),
    .TAG_W (6),
    .OPC_W (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .dispatch_enable      (dispatch_enable),
    .dispatch_rs1_data    (dispatch_rs1_data),
    .dispatch_rs2_data    (dispatch_rs2_data),
    .dispatch_rs1_tag     (dispatch_rs1_tag),
    .dispatch_rs2_tag     (dispatch_rs2_tag),
    .dispatch_rs1_data_val(dispatch_rs1_data_val),
    .dispatch_rs2_data_val(dispatch_rs2_data_val),
    .dispatch_opcode      (dispatch_opcode),
    .dispatch_rd_tag      (dispatch_rd_tag),
    .issueque_full        (issueque_full),
    .issueque_count       (issueque_count),
    .cdb_tag              (cdb_tag),
    .cdb_data             (cdb_data),
    .cdb_valid            (cdb_valid),
    .issueque_flush       (issueque_flush),
    .issueque_ready       (issueque_ready),
    .issueque_rs_data     (issueque_rs_data),
    .issueque_rt_data     (issueque_rt_data),
    .issueque_rd_tag      (issueque_rd_tag),
    .issueque_opcode      (issueque_opcode),
    .issueblk_done        (issueblk_done)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic en, input logic [5:0] rd,
                          input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                          input logic [31:0] d2, input logic [5:0] t2, input logic v2);
    dispatch_enable       = en;
    dispatch_rd_tag       = rd;
    dispatch_opcode       = rd[3:0];
    dispatch_rs1_data     = d1;
    dispatch_rs1_tag      = t1;
    dispatch_rs1_data_val = v1;
    dispatch_rs2_data     = d2;
    dispatch_rs2_tag      = t2;
    dispatch_rs2_data_val = v2;
  endtask

  task automatic set_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issueque_flush = 1'b0;
    issueblk_done = 1'b0;
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    set_cdb(1'b0, 6'd0, 32'd0);
    tick();
    tick();
    checks++;
    if ({issueque_full, issueque_count, issueque_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_status: got full=%b count=%0d ready=%b, want 0/0/0",
               issueque_full, issueque_count, issueque_ready);
    end
    checks++;
    if ({issueque_rs_data, issueque_rt_data, issueque_rd_tag, issueque_opcode} !== 74'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rs=%h rt=%h rd=%0d opc=%0d, want all 0",
               issueque_rs_data, issueque_rt_data, issueque_rd_tag, issueque_opcode);
    end
    reset = 1'b0;
    tick();
  endtask

  // Dispatch rd 1,2,3 on edges 1-3; execute accepts from edge 3 on: count 1,2,2,1,0.
  task automatic test_back_to_back();
    logic [3:0] exp_cnt [5];
    logic [5:0] exp_rd  [5];
    logic       exp_rdy [5];
    exp_cnt = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd0};
    exp_rd  = '{6'd1, 6'd1, 6'd2, 6'd3, 6'd0};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        set_disp(1'b1, 6'(k + 1), 32'h100 + 32'(k + 1), 6'd0, 1'b1, 32'h200, 6'd0, 1'b1);
      end else begin
        set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
      end
      issueblk_done = (k >= 2);
      tick();
      checks++;
      if (issueque_count !== exp_cnt[k] || issueque_ready !== exp_rdy[k] ||
          issueque_rd_tag !== exp_rd[k]) begin
        errors++;
        $display("FAIL b2b_edge%0d: got count=%0d ready=%b rd=%0d, want %0d/%b/%0d",
                 k + 1, issueque_count, issueque_ready, issueque_rd_tag,
                 exp_cnt[k], exp_rdy[k], exp_rd[k]);
      end
    end
    checks++;
    if (issueque_rs_data !== 32'd0) begin
      errors++;
      $display("FAIL b2b_idle_data: got rs=%h, want 0", issueque_rs_data);
    end
    issueblk_done = 1'b0;
  endtask

  task automatic test_out_of_order();
    set_disp(1'b1, 6'd10, 32'd0, 6'd5, 1'b0, 32'h22, 6'd0, 1'b1);
    tick();
    checks++;
    if (issueque_count !== 4'd1 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL ooo_a_waits: got count=%0d ready=%b, want 1/0",
               issueque_count, issueque_ready);
    end
    set_disp(1'b1, 6'd11, 32'h11, 6'd0, 1'b1, 32'h12, 6'd0, 1'b1);
    tick();
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    checks++;
    if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd11 || issueque_rs_data !== 32'h11) begin
      errors++;
      $display("FAIL ooo_b_first: got ready=%b rd=%0d rs=%h, want 1/11/00000011",
               issueque_ready, issueque_rd_tag, issueque_rs_data);
    end
    issueblk_done = 1'b1;
    tick();
    issueblk_done = 1'b0;
    set_cdb(1'b1, 6'd5, 32'hDEAD);
    checks++;
    if (issueque_count !== 4'd1 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL ooo_no_forward: got count=%0d ready=%b, want 1/0",
               issueque_count, issueque_ready);
    end
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    checks++;
    if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd10 ||
        issueque_rs_data !== 32'hDEAD || issueque_rt_data !== 32'h22 ||
        issueque_opcode !== 4'd10) begin
      errors++;
      $display("FAIL ooo_wakeup: got ready=%b rd=%0d rs=%h rt=%h opc=%0d, want 1/10/dead/22/10",
               issueque_ready, issueque_rd_tag, issueque_rs_data, issueque_rt_data,
               issueque_opcode);
    end
    issueblk_done = 1'b1;
    tick();
    issueblk_done = 1'b0;
    checks++;
    if (issueque_count !== 4'd0) begin
      errors++;
      $display("FAIL ooo_drain: got count=%0d, want 0", issueque_count);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      set_disp(1'b1, 6'(20 + k), 32'd0, 6'd40, 1'b0, 32'h5, 6'd0, 1'b1);
      tick();
    end
    checks++;
    if (issueque_full !== 1'b1 || issueque_count !== 4'd8) begin
      errors++;
      $display("FAIL full_set: got full=%b count=%0d, want 1/8", issueque_full, issueque_count);
    end
    set_disp(1'b1, 6'd28, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
    tick();
    checks++;
    if (issueque_count !== 4'd8 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: got count=%0d ready=%b, want 8/0", issueque_count, issueque_ready);
    end
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    set_cdb(1'b1, 6'd40, 32'h77);
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    checks++;
    if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd20 || issueque_rs_data !== 32'h77) begin
      errors++;
      $display("FAIL full_wake_all: got ready=%b rd=%0d rs=%h, want 1/20/77",
               issueque_ready, issueque_rd_tag, issueque_rs_data);
    end
    // Dispatch concurrent with issue while full must still be dropped.
    set_disp(1'b1, 6'd29, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    checks++;
    if (issueque_count !== 4'd7 || issueque_full !== 1'b0) begin
      errors++;
      $display("FAIL full_concurrent: got count=%0d full=%b, want 7/0",
               issueque_count, issueque_full);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'(21 + k)) begin
        errors++;
        $display("FAIL full_drain%0d: got ready=%b rd=%0d, want 1/%0d",
                 k, issueque_ready, issueque_rd_tag, 21 + k);
      end
      tick();
    end
    issueblk_done = 1'b0;
    checks++;
    if (issueque_count !== 4'd0 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got count=%0d ready=%b, want 0/0", issueque_count, issueque_ready);
    end
  endtask

  task automatic test_bypass();
    set_disp(1'b1, 6'd30, 32'h1, 6'd0, 1'b1, 32'd0, 6'd9, 1'b0);
    set_cdb(1'b1, 6'd9, 32'h55);
    tick();
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    set_cdb(1'b0, 6'd0, 32'd0);
    checks++;
    if (issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd30 ||
        issueque_rt_data !== 32'h55 || issueque_rs_data !== 32'h1) begin
      errors++;
      $display("FAIL bypass: got ready=%b rd=%0d rs=%h rt=%h, want 1/30/1/55",
               issueque_ready, issueque_rd_tag, issueque_rs_data, issueque_rt_data);
    end
    issueblk_done = 1'b1;
    tick();
    issueblk_done = 1'b0;
  endtask

  task automatic test_middle_issue();
    set_disp(1'b1, 6'd40, 32'd0, 6'd12, 1'b0, 32'h2, 6'd0, 1'b1);
    tick();
    set_disp(1'b1, 6'd41, 32'd0, 6'd13, 1'b0, 32'h2, 6'd0, 1'b1);
    tick();
    set_disp(1'b1, 6'd42, 32'h4, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
    tick();
    set_disp(1'b1, 6'd43, 32'h3, 6'd0, 1'b1, 32'd0, 6'd14, 1'b0);
    tick();
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    checks++;
    if (issueque_count !== 4'd4 || issueque_rd_tag !== 6'd42) begin
      errors++;
      $display("FAIL mid_select: got count=%0d rd=%0d, want 4/42", issueque_count, issueque_rd_tag);
    end
    // Issue index 2 while the CDB wakes index 3; it must land in index 2 with its data.
    issueblk_done = 1'b1;
    set_cdb(1'b1, 6'd14, 32'h99);
    tick();
    issueblk_done = 1'b0;
    set_cdb(1'b0, 6'd0, 32'd0);
    checks++;
    if (issueque_count !== 4'd3 || issueque_ready !== 1'b1 || issueque_rd_tag !== 6'd43 ||
        issueque_rt_data !== 32'h99 || issueque_rs_data !== 32'h3) begin
      errors++;
      $display("FAIL mid_shift_wake: got count=%0d ready=%b rd=%0d rs=%h rt=%h, want 3/1/43/3/99",
               issueque_count, issueque_ready, issueque_rd_tag, issueque_rs_data,
               issueque_rt_data);
    end
    set_cdb(1'b1, 6'd13, 32'hB);
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    checks++;
    if (issueque_rd_tag !== 6'd41 || issueque_rs_data !== 32'hB) begin
      errors++;
      $display("FAIL mid_age_order: got rd=%0d rs=%h, want 41/b", issueque_rd_tag, issueque_rs_data);
    end
    issueblk_done = 1'b1;
    tick();
    checks++;
    if (issueque_rd_tag !== 6'd43 || issueque_count !== 4'd2) begin
      errors++;
      $display("FAIL mid_next: got rd=%0d count=%0d, want 43/2", issueque_rd_tag, issueque_count);
    end
    tick();
    issueblk_done = 1'b0;
    checks++;
    if (issueque_count !== 4'd1 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_oldest_waits: got count=%0d ready=%b, want 1/0",
               issueque_count, issueque_ready);
    end
    set_cdb(1'b1, 6'd12, 32'hC);
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    issueblk_done = 1'b1;
    tick();
    issueblk_done = 1'b0;
    checks++;
    if (issueque_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_drain: got count=%0d, want 0", issueque_count);
    end
  endtask

  // kind 0: flush, kind 1: reset, each asserted with a dispatch and an issue pending.
  task automatic test_flush(input int kind);
    for (int k = 0; k < 5; k++) begin
      set_disp(1'b1, 6'(50 + k), 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
      tick();
    end
    checks++;
    if (issueque_count !== 4'd5) begin
      errors++;
      $display("FAIL flush%0d_fill: got count=%0d, want 5", kind, issueque_count);
    end
    set_disp(1'b1, 6'd55, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
    issueblk_done = 1'b1;
    if (kind == 0) issueque_flush = 1'b1;
    else reset = 1'b1;
    tick();
    issueque_flush = 1'b0;
    reset = 1'b0;
    issueblk_done = 1'b0;
    set_disp(1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    checks++;
    if (issueque_count !== 4'd0 || issueque_ready !== 1'b0 || issueque_full !== 1'b0 ||
        issueque_rd_tag !== 6'd0 || issueque_rs_data !== 32'd0) begin
      errors++;
      $display("FAIL flush%0d_clear: got count=%0d ready=%b full=%b rd=%0d rs=%h, want all 0",
               kind, issueque_count, issueque_ready, issueque_full, issueque_rd_tag,
               issueque_rs_data);
    end
    tick();
    checks++;
    if (issueque_count !== 4'd0 || issueque_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush%0d_absent: got count=%0d ready=%b, want 0/0",
               kind, issueque_count, issueque_ready);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_order();
    test_full();
    test_bypass();
    test_middle_issue();
    test_flush(0);
    test_flush(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
